gray_bist_ctrl: RTL and testbench
=================================

GRAY_BIST_CTRL -- requirements
Module: gray_bist_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: converter data width in bits.
REQ-002 Parameter LAT, default 2: cycles from stim_bin sampled (conv_en=1) to the matching ret_bin valid; legal range 1..8.
REQ-003 Parameter PASSES, default 1: number of full 2^WIDTH code sweeps per test; legal range 1..255.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a test; acted on only in IDLE or DONE.
REQ-007 pause  input  1  level; while high the converter pipeline and all test progress freeze.
REQ-008 abort  input  1  one-cycle request to end a running test early, reported as fail.
REQ-009 stim_bin  output  WIDTH  binary stimulus to the external gray/binary converter pair.
REQ-010 conv_en  output  1  enable to both converter stages.
REQ-011 ret_bin  input  WIDTH  round-trip binary returned by the converter pair.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  one-cycle pulse on entry to DONE.
REQ-014 pass  output  1  result of the last completed test; valid while in DONE.

Function
REQ-015 FSM states IDLE, RUN, DRAIN, DONE; IDLE/DONE + start -> RUN; RUN -> DRAIN after the last stimulus issues; DRAIN -> DONE after LAT advancing cycles; abort in RUN/DRAIN -> DONE with pass=0.
REQ-016 In RUN, each cycle with pause=0: conv_en=1, stim_bin=sweep counter, counter +1 modulo 2^WIDTH; total stimuli = PASSES*2^WIDTH, first value 0.
REQ-017 In DRAIN with pause=0: conv_en=1 and stim_bin holds its last value; issued values are marked not-checked.
REQ-018 conv_en=0 in IDLE, DONE, and any cycle with pause=1.
REQ-019 A LAT-deep expected-value/valid shift pipeline advances only when conv_en=1; with no pause, ret_bin is compared with the value issued exactly LAT cycles earlier.
REQ-020 Any valid mismatch clears an internal sticky ok flag; pass is loaded from ok on entry to DONE.
REQ-021 start while busy is ignored; start and abort in the same RUN cycle: abort wins.
REQ-022 On start from DONE: pass clears to 0, ok sets, counters and valid pipeline clear, all in the same edge.
REQ-023 pause asserted in the same cycle as the last RUN stimulus: that stimulus is not issued until pause drops.
REQ-024 Sweep counter wraps 2^WIDTH-1 -> 0 between passes without an idle cycle; the pass counter is 8 bits.
REQ-025 done pulses exactly once per test, including aborted tests.

Reset
REQ-026 rst forces IDLE, stim_bin=0, conv_en=0, busy=0, done=0, pass=0, all counters and the valid pipeline cleared, ok set; rst mid-test abandons it with no done pulse.

Configuration
REQ-027 Macro GRAY_BIST_ERRLOG_EN defined: add outputs err_cnt (16 bits, saturating mismatch count) and first_fail (WIDTH bits, expected value of the first mismatch); both clear on start and reset and hold in DONE.
REQ-028 GRAY_BIST_ERRLOG_EN undefined: those ports and their logic are absent; all other behaviour is identical.

Structure
REQ-029 Shared package gray_pkg holds the FSM state enum (IDLE, RUN, DRAIN, DONE), the default WIDTH and LAT constants, and the err_cnt width constant.
REQ-030 One sub-module, gray_bist_expect: the LAT-deep expected-value/valid pipeline with an advance enable and a mismatch output.

Verification
REQ-031 Correct converter pair (LAT=2), start at cycle 0 -> stim_bin 0..15, busy for 18 cycles, done pulse, pass=1.
REQ-032 Model corrupts the return for value 9 (returns 11) -> pass=0; with GRAY_BIST_ERRLOG_EN, err_cnt=1 and first_fail=9.
REQ-033 pause high for 5 cycles mid-sweep at stim_bin=6 -> conv_en=0 and stim_bin=6 held throughout, then resume; pass=1 and the test takes 5 extra cycles.
REQ-034 abort at stim_bin=3 -> DONE next edge, done pulses once, pass=0; start then reruns and yields pass=1.
REQ-035 PASSES=2 -> stim_bin 0..15, 0..15 with no gap, busy for 34 cycles, pass=1; start during busy has no effect.
REQ-036 rst asserted in DRAIN -> next cycle IDLE, all outputs 0, no done pulse.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the gray/binary converter BIST controller.
//   state_t      : controller FSM states
//   DEF_WIDTH    : default converter data width
//   DEF_LAT      : default converter round-trip latency
//   ERR_CNT_W    : width of the optional mismatch counter
//   PASS_CNT_W   : width of the sweep pass counter
//   DRAIN_CNT_W  : width of the drain cycle counter (covers LAT up to 8)
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_LAT     = 2;
  localparam int unsigned ERR_CNT_W   = 16;
  localparam int unsigned PASS_CNT_W  = 8;
  localparam int unsigned DRAIN_CNT_W = 4;

endpackage

// File: rtl/gray_bist_expect.sv
// Expected-value / valid shift pipeline, LAT stages deep, that tracks the
// external converter pair and flags a mismatch on the returned value.
// Optional macro GRAY_BIST_ERRLOG_EN exposes the expected value at the tap.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_clr          : synchronous clear of the pipeline (new test)
//   i_adv          : advance enable, same as the converter enable
//   i_exp, i_vld   : value issued this cycle and whether it is checked
//   i_ret          : round-trip value returned by the converter pair
//   o_mismatch_c   : combinational, valid compare failed this cycle
//   o_exp          : (GRAY_BIST_ERRLOG_EN) expected value at the compare tap
module gray_bist_expect
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LAT   = DEF_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic [WIDTH-1:0] i_exp,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_ret,
`ifdef GRAY_BIST_ERRLOG_EN
  output logic [WIDTH-1:0] o_exp,
`endif
  output logic             o_mismatch_c
);

  logic [LAT*WIDTH-1:0] r_exp_sr;
  logic [LAT-1:0]       r_vld_sr;
  logic [WIDTH-1:0]     w_tap;

  // Newest entry sits in the low slot; the oldest lines up with i_ret.
  if (LAT == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (rst || i_clr) begin
        r_exp_sr <= '0;
        r_vld_sr <= '0;
      end else if (i_adv) begin
        r_exp_sr <= i_exp;
        r_vld_sr <= i_vld;
      end
    end
  end else begin : g_many
    always_ff @(posedge clk) begin
      if (rst || i_clr) begin
        r_exp_sr <= '0;
        r_vld_sr <= '0;
      end else if (i_adv) begin
        r_exp_sr <= {r_exp_sr[(LAT-1)*WIDTH-1:0], i_exp};
        r_vld_sr <= {r_vld_sr[LAT-2:0], i_vld};
      end
    end
  end

  assign w_tap = r_exp_sr[LAT*WIDTH-1 -: WIDTH];

  // Compare only on advancing cycles; a frozen converter returns stale data.
  assign o_mismatch_c = i_adv & r_vld_sr[LAT-1] & (w_tap != i_ret);

`ifdef GRAY_BIST_ERRLOG_EN
  assign o_exp = w_tap;
`endif

endmodule

// File: rtl/gray_bist_ctrl.sv
// BIST controller for an external binary->gray->binary converter pair.
// Sweeps every code PASSES times, drains the converter latency, and reports
// pass/fail from a sticky compare flag.
// Optional macro GRAY_BIST_ERRLOG_EN adds err_cnt and first_fail outputs.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a test (IDLE/DONE only)
//   pause      : freeze converter and test progress while high
//   abort      : end a running test early with pass=0
//   stim_bin   : stimulus to the converter pair
//   conv_en    : enable to both converter stages
//   ret_bin    : round-trip value from the converter pair
//   busy       : high in RUN and DRAIN
//   done       : one-cycle pulse on entry to DONE
//   pass       : result of the last completed test
//   err_cnt    : (GRAY_BIST_ERRLOG_EN) saturating mismatch count
//   first_fail : (GRAY_BIST_ERRLOG_EN) expected value of the first mismatch
module gray_bist_ctrl
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned LAT    = DEF_LAT,
  parameter int unsigned PASSES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 abort,
  output logic [WIDTH-1:0]     stim_bin,
  output logic                 conv_en,
  input  logic [WIDTH-1:0]     ret_bin,
  output logic                 busy,
  output logic                 done,
  output logic                 pass
`ifdef GRAY_BIST_ERRLOG_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0]     first_fail
`endif
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_last;
  logic [PASS_CNT_W-1:0]  r_pass_cnt;
  logic [DRAIN_CNT_W-1:0] r_drain;
  logic                   r_ok;
  logic                   r_done;
  logic                   r_pass;

  logic w_busy;
  logic w_adv;
  logic w_issue;
  logic w_chk;
  logic w_last_stim;
  logic w_drain_end;
  logic w_clr;
  logic w_enter_done;
  logic w_pass_nxt;
  logic w_mismatch;

  assign w_busy  = (r_state == RUN) || (r_state == DRAIN);
  assign w_adv   = w_busy & ~pause;
  assign w_issue = (r_state == RUN) & ~pause;
  assign w_chk   = (r_state == RUN);

  assign w_last_stim = w_issue && (r_cnt == '1) &&
                       (r_pass_cnt == PASS_CNT_W'(PASSES - 1));
  assign w_drain_end = (r_state == DRAIN) && !pause &&
                       (r_drain == DRAIN_CNT_W'(LAT - 1));

  // Next-state and test control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_pass_nxt  = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_clr       = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = DONE;
        end else if (w_last_stim) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          w_state_nxt = DONE;
        end else if (w_drain_end) begin
          w_state_nxt = DONE;
          // The final stimulus is compared on this same edge.
          w_pass_nxt  = r_ok & ~w_mismatch;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_enter_done = (w_state_nxt == DONE) && (r_state != DONE);
  end

  // State register and test counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last     <= '0;
      r_pass_cnt <= '0;
      r_drain    <= '0;
      r_ok       <= 1'b1;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_enter_done;
      if (w_clr) begin
        r_cnt      <= '0;
        r_last     <= '0;
        r_pass_cnt <= '0;
        r_drain    <= '0;
        r_ok       <= 1'b1;
        r_pass     <= 1'b0;
      end else begin
        if (w_issue) begin
          r_last <= r_cnt;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_pass_cnt <= r_pass_cnt + 1'b1;
          end
        end
        if ((r_state == DRAIN) && !pause) begin
          r_drain <= r_drain + 1'b1;
        end
        if (w_mismatch) begin
          r_ok <= 1'b0;
        end
        if (w_enter_done) begin
          r_pass <= w_pass_nxt;
        end
      end
    end
  end

`ifdef GRAY_BIST_ERRLOG_EN
  logic [WIDTH-1:0]     w_exp;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [WIDTH-1:0]     r_first_fail;

  // Mismatch log; nothing compares outside RUN/DRAIN so it holds in DONE.
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_err_cnt    <= '0;
      r_first_fail <= '0;
    end else if (w_mismatch) begin
      if (r_err_cnt == '0) begin
        r_first_fail <= w_exp;
      end
      if (r_err_cnt != '1) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign err_cnt    = r_err_cnt;
  assign first_fail = r_first_fail;
`endif

  gray_bist_expect #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_expect (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_adv        (w_adv),
    .i_exp        (stim_bin),
    .i_vld        (w_chk),
    .i_ret        (ret_bin),
`ifdef GRAY_BIST_ERRLOG_EN
    .o_exp        (w_exp),
`endif
    .o_mismatch_c (w_mismatch)
  );

  // In DRAIN and DONE the last issued value is held on the stimulus bus.
  assign stim_bin = (r_state == RUN) ? r_cnt : r_last;
  assign conv_en  = w_adv;
  assign busy     = w_busy;
  assign done     = r_done;
  assign pass     = r_pass;

endmodule

// File: tb/tb_gray_bist_ctrl.sv
// Self-checking bench for gray_bist_ctrl: two instances (PASSES=1 and 2),
// a behavioural converter pair with optional corruption, and a reference
// model derived from the sweep rules (issue order, drain length, verdict).
module tb_gray_bist_ctrl;

  localparam int W   = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst, start, pause, abort;
  logic sel;

  logic [W-1:0] stim_a, stim_b, ret_a, ret_b;
  logic conv_a, conv_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
`ifdef GRAY_BIST_ERRLOG_EN
  logic [15:0]  err_cnt_a, err_cnt_b;
  logic [W-1:0] first_fail_a, first_fail_b;
`endif

  logic start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  logic [W-1:0] o_stim;
  logic o_conv, o_busy, o_done, o_pass;
  assign o_stim = sel ? stim_b : stim_a;
  assign o_conv = sel ? conv_b : conv_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_pass = sel ? pass_b : pass_a;

  int checks = 0;
  int errs   = 0;

  bit           corrupt_en  = 1'b0;
  logic [W-1:0] corrupt_val = '0;
  logic [W-1:0] corrupt_ret = '0;

  always #5 clk = ~clk;

  gray_bist_ctrl #(.WIDTH(W), .LAT(LAT), .PASSES(1)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start_a),
    .pause      (pause),
    .abort      (abort),
    .stim_bin   (stim_a),
    .conv_en    (conv_a),
    .ret_bin    (ret_a),
    .busy       (busy_a),
    .done       (done_a),
`ifdef GRAY_BIST_ERRLOG_EN
    .err_cnt    (err_cnt_a),
    .first_fail (first_fail_a),
`endif
    .pass       (pass_a)
  );

  gray_bist_ctrl #(.WIDTH(W), .LAT(LAT), .PASSES(2)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .pause      (pause),
    .abort      (abort),
    .stim_bin   (stim_b),
    .conv_en    (conv_b),
    .ret_bin    (ret_b),
    .busy       (busy_b),
    .done       (done_b),
`ifdef GRAY_BIST_ERRLOG_EN
    .err_cnt    (err_cnt_b),
    .first_fail (first_fail_b),
`endif
    .pass       (pass_b)
  );

  // Round trip through gray code, with an optional injected fault.
  function automatic logic [W-1:0] conv(input logic [W-1:0] v);
    logic [W-1:0] g, b;
    g = v ^ (v >> 1);
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    if (corrupt_en && (v == corrupt_val)) b = corrupt_ret;
    return b;
  endfunction

  // Converter pairs: LAT-deep, frozen whenever conv_en is low.
  logic [W-1:0] pa [LAT];
  logic [W-1:0] pb [LAT];
  always @(posedge clk) begin
    if (conv_a) begin
      pa[0] <= conv(stim_a);
      for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    end
    if (conv_b) begin
      pb[0] <= conv(stim_b);
      for (int i = 1; i < LAT; i++) pb[i] <= pb[i-1];
    end
  end
  assign ret_a = pa[LAT-1];
  assign ret_b = pb[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full test on the selected instance, checked cycle by cycle.
  task automatic run_test(input string tag, input int pause_at, input int pause_len,
                          input bit rnd, input int start_mid, input bit exp_pass);
    int n, k, cyc, pz_left, nbusy, npaused;
    bit first;
    n = (sel ? 2 : 1) * (1 << W);
    k = 0; cyc = 0; nbusy = 0; npaused = 0; first = 1'b1;
    pz_left = pause_len;
    start = 1'b1; pause = 1'b0; abort = 1'b0;
    @(posedge clk);
    while (cyc < 1000) begin
      @(negedge clk);
      start = (k == start_mid);
      if ((k == pause_at) && (pz_left > 0)) begin
        pause = 1'b1;
        pz_left--;
      end else begin
        pause = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      #1;
      chk({tag, "_busy"}, o_busy, (k < n + LAT));
      if (!o_busy || !(k < n + LAT)) break;
      if (first) begin
        chk({tag, "_pass_clr"}, o_pass, 0);
        first = 1'b0;
      end
      nbusy++;
      if (pause) npaused++;
      chk({tag, "_conv_en"}, o_conv, !pause);
      chk({tag, "_stim"}, o_stim, (k < n) ? (k % (1 << W)) : ((1 << W) - 1));
      chk({tag, "_done_busy"}, o_done, 0);
      if (o_conv) k++;
      cyc++;
    end
    if (cyc >= 1000) chk({tag, "_timeout"}, o_busy, 0);
    chk({tag, "_cycles"}, nbusy, n + LAT + npaused);
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_pass"}, o_pass, exp_pass);
    start = 1'b0; pause = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_done_once"}, o_done, 0);
    chk({tag, "_idle"}, o_busy, 0);
  endtask

  initial begin
    int k, cyc;
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_stim_a", stim_a, 0);
    chk("rst_conv_a", conv_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_pass_a", pass_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_pass_b", pass_b, 0);

    // Clean sweep, then a corrupted return for value 9.
    run_test("clean", -1, 0, 1'b0, -1, 1'b1);
    corrupt_en = 1'b1; corrupt_val = 4'd9; corrupt_ret = 4'd11;
    run_test("corrupt9", -1, 0, 1'b0, -1, 1'b0);
`ifdef GRAY_BIST_ERRLOG_EN
    chk("err_cnt", err_cnt_a, 1);
    chk("first_fail", first_fail_a, 9);
`endif
    corrupt_en = 1'b0;

    // Pause mid-sweep, and pause on the final stimulus.
    run_test("pause6", 6, 5, 1'b0, -1, 1'b1);
    run_test("pause_last", 15, 3, 1'b0, -1, 1'b1);

    // Abort while stimulus 3 is on the bus.
    start = 1'b1;
    @(posedge clk);
    k = 0; cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      start = 1'b0; pause = 1'b0;
      abort = (k == 3);
      #1;
      if (abort) begin
        chk("abort_stim", o_stim, 3);
        break;
      end
      if (o_conv) k++;
      cyc++;
    end
    @(negedge clk); abort = 1'b0; #1;
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 1);
    chk("abort_pass", o_pass, 0);
    @(negedge clk); #1;
    chk("abort_done_once", o_done, 0);
    run_test("rerun", -1, 0, 1'b0, -1, 1'b1);

    // Two-pass instance, with a start request while it is busy.
    sel = 1'b1;
    run_test("p2_clean", -1, 0, 1'b0, 10, 1'b1);
    corrupt_en = 1'b1; corrupt_val = 4'd15; corrupt_ret = 4'd7;
    run_test("p2_corrupt15", -1, 0, 1'b0, -1, 1'b0);
    corrupt_en = 1'b0;

    // Randomised pause patterns and injected faults on both instances.
    for (int t = 0; t < 6; t++) begin
      sel = t[0];
      corrupt_en  = ($urandom_range(0, 1) == 1);
      corrupt_val = W'($urandom_range(0, 15));
      corrupt_ret = corrupt_val ^ W'(1 << $urandom_range(0, W - 1));
      run_test("rnd", -1, 0, 1'b1, -1, !corrupt_en);
    end
    corrupt_en = 1'b0;

    // Reset during DRAIN abandons the test without a done pulse.
    sel = 1'b0;
    start = 1'b1;
    @(posedge clk);
    k = 0; cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      start = 1'b0; pause = 1'b0;
      rst = (k == 16);
      #1;
      if (rst) begin
        chk("rstdrain_busy_before", o_busy, 1);
        break;
      end
      if (o_conv) k++;
      cyc++;
    end
    @(negedge clk); rst = 1'b0; #1;
    chk("rstdrain_busy", o_busy, 0);
    chk("rstdrain_conv", o_conv, 0);
    chk("rstdrain_stim", o_stim, 0);
    chk("rstdrain_done", o_done, 0);
    chk("rstdrain_pass", o_pass, 0);
    @(negedge clk); #1;
    chk("rstdrain_no_done", o_done, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
